dds_wave_gen: RTL and testbench

Parametrised DDS core for the next waveform-generator generation: a phase accumulator plus a single sine ROM, with triangle, sawtooth and square computed arithmetically from the phase.
- Waveform changes are deferred to the phase wrap, so the output never glitches mid-period.
- Phase offset, sync clear and a data-valid pipeline are included.
- Sits between the control/register block (frequency, waveform, offset) and the DAC interface.

---
 rtl/dds_pkg.sv | 24 ++
 rtl/dds_wave_gen_if.sv | 29 ++
 rtl/dds_sin_rom.sv | 56 +++++
 rtl/dds_wave_gen.sv | 123 ++++++++++++
 tb/tb_dds_wave_gen.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform generator: wave codes, pipeline
// latency and the phase-to-sample scaling helper.
package dds_pkg;

  typedef enum logic [1:0] {
    WAV_SIN = 2'b00,
    WAV_TRI = 2'b01,
    WAV_SAW = 2'b10,
    WAV_SQU = 2'b11
  } wav_e;

  localparam int DDS_LAT = 3;

  // Narrower samples keep the top bits of the phase; wider samples pad zeros on the LSB side.
  function automatic logic [31:0] scale_addr(input logic [31:0] a,
                                             input int addr_bit,
                                             input int data_bit);
    if (data_bit <= addr_bit) begin
      return a >> (addr_bit - data_bit);
    end
    return a << (data_bit - addr_bit);
  endfunction

endpackage

// File: rtl/dds_wave_gen_if.sv
// Control and sample bus between the register block, the DDS core and the DAC side.
interface dds_wave_gen_if
  import dds_pkg::*;
#(
  parameter int PHASE_BIT = 32,
  parameter int ADDR_BIT  = 12,
  parameter int DATA_BIT  = 12
);

  logic                 en;
  logic                 clr;
  logic [PHASE_BIT-1:0] freq_word;
  logic [ADDR_BIT-1:0]  phase_offset;
  wav_e                 wav_select;
  wav_e                 wav_active;
  logic [DATA_BIT-1:0]  data;
  logic                 data_valid;

  modport master (
    output en, clr, freq_word, phase_offset, wav_select,
    input  wav_active, data, data_valid
  );

  modport slave (
    input  en, clr, freq_word, phase_offset, wav_select,
    output wav_active, data, data_valid
  );

endinterface

// File: rtl/dds_sin_rom.sv
// Full-period sine table with a registered read; contents are generated at
// elaboration with fixed-point arithmetic so no real math is needed in hardware.
module dds_sin_rom
  import dds_pkg::*;
#(
  parameter int ADDR_BIT = 12,
  parameter int DATA_BIT = 12
) (
  input  logic                sclk,
  input  logic [ADDR_BIT-1:0] addr,
  output logic [DATA_BIT-1:0] data
);

  localparam int DEPTH = 1 << ADDR_BIT;

  // Quadrant folding plus a Q30 Horner Taylor series up to x^13 on [0, pi/2].
  function automatic logic [DATA_BIT-1:0] sin_entry(input int k);
    longint one, pi_fx, quarter, r, ph, x, x2, t, s, v, half, amp;
    int     quad;
    one     = longint'(1) << 30;
    pi_fx   = 64'sd3373259426;
    quarter = longint'(1) << (ADDR_BIT - 2);
    quad    = (k >> (ADDR_BIT - 2)) & 3;
    r       = longint'(k) & (quarter - 1);
    ph      = quad[0] ? quarter - r : r;
    x       = (ph * 2 * pi_fx) >>> ADDR_BIT;
    x2      = (x * x) >>> 30;
    t       = one;
    t       = one - ((x2 * t) >>> 30) / 156;
    t       = one - ((x2 * t) >>> 30) / 110;
    t       = one - ((x2 * t) >>> 30) / 72;
    t       = one - ((x2 * t) >>> 30) / 42;
    t       = one - ((x2 * t) >>> 30) / 20;
    t       = one - ((x2 * t) >>> 30) / 6;
    s       = (x * t) >>> 30;
    half    = longint'(1) << (DATA_BIT - 1);
    amp     = half - 1;
    v       = (s * amp + (one >>> 1)) >>> 30;
    if (v > amp) begin
      v = amp;
    end
    return DATA_BIT'(quad[1] ? half - v : half + v);
  endfunction

  logic [DATA_BIT-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [DATA_BIT-1:0] SIN_VAL = sin_entry(i);
    assign rom[i] = SIN_VAL;
  end

  always_ff @(posedge sclk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS core: phase accumulator, sine ROM lookup and arithmetic triangle/saw/square,
// with waveform changes deferred to the phase wrap so no period is mixed.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int DATA_BIT  = 12,
  parameter int ADDR_BIT  = 12,
  parameter int PHASE_BIT = 32
) (
  input  logic           sclk,
  input  logic           rst_n,
  dds_wave_gen_if.slave  bus
);

  logic [PHASE_BIT-1:0] acc;
  logic [PHASE_BIT-1:0] acc_sum;
  logic                 acc_carry;
  wav_e                 wav_active_q;

  logic [ADDR_BIT-1:0]  addr1;
  wav_e                 sel1;
  logic                 v1;

  logic [DATA_BIT-1:0]  sin2;
  logic [DATA_BIT-1:0]  tri_q;
  logic [DATA_BIT-1:0]  saw_q;
  logic [DATA_BIT-1:0]  squ_q;
  wav_e                 sel2;
  logic                 v2;

  logic [DATA_BIT-1:0]  data_q;
  logic                 data_valid_q;

  logic [ADDR_BIT-2:0]  tri_fold;
  logic [ADDR_BIT-1:0]  tri_ramp;
  logic [DATA_BIT-1:0]  tri_val;
  logic [DATA_BIT-1:0]  saw_val;
  logic [DATA_BIT-1:0]  squ_val;
  logic [DATA_BIT-1:0]  mux_val;

  always_comb begin
    {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, bus.freq_word};
    tri_fold = addr1[ADDR_BIT-1] ? ~addr1[ADDR_BIT-2:0] : addr1[ADDR_BIT-2:0];
    tri_ramp = {tri_fold, 1'b0};
    tri_val  = DATA_BIT'(scale_addr(32'(tri_ramp), ADDR_BIT, DATA_BIT));
    saw_val  = DATA_BIT'(scale_addr(32'(addr1), ADDR_BIT, DATA_BIT));
    squ_val  = {DATA_BIT{~addr1[ADDR_BIT-1]}};
    mux_val  = sin2;
    case (sel2)
      WAV_TRI: mux_val = tri_q;
      WAV_SAW: mux_val = saw_q;
      WAV_SQU: mux_val = squ_q;
      default: mux_val = sin2;
    endcase
  end

  // The launched sample uses the pre-update phase and the waveform active before any switch.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      addr1        <= '0;
      sel1         <= WAV_SIN;
      v1           <= 1'b0;
      wav_active_q <= WAV_SIN;
    end else if (bus.clr) begin
      acc          <= '0;
      v1           <= 1'b0;
      wav_active_q <= bus.wav_select;
    end else begin
      v1 <= bus.en;
      if (bus.en) begin
        acc   <= acc_sum;
        addr1 <= acc[PHASE_BIT-1 -: ADDR_BIT] + bus.phase_offset;
        sel1  <= wav_active_q;
        if (acc_carry) begin
          wav_active_q <= bus.wav_select;
        end
      end else begin
        wav_active_q <= bus.wav_select;
      end
    end
  end

  dds_sin_rom #(
    .ADDR_BIT (ADDR_BIT),
    .DATA_BIT (DATA_BIT)
  ) u_sin_rom (
    .sclk (sclk),
    .addr (addr1),
    .data (sin2)
  );

  // Lookup and output stages; data only moves when a valid sample reaches the end.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tri_q        <= '0;
      saw_q        <= '0;
      squ_q        <= '0;
      sel2         <= WAV_SIN;
      v2           <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else if (bus.clr) begin
      v2           <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      tri_q        <= tri_val;
      saw_q        <= saw_val;
      squ_q        <= squ_val;
      sel2         <= sel1;
      v2           <= v1;
      data_valid_q <= v2;
      if (v2) begin
        data_q <= mux_val;
      end
    end
  end

  assign bus.wav_active = wav_active_q;
  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: a phase/waveform model compared every cycle, plus
// directed literal expectations taken from hand-computed waveform values.
module tb_dds_wave_gen;
  import dds_pkg::*;

  localparam int  PB = 32;
  localparam int  AB = 12;
  localparam int  DB = 12;
  localparam real PI = 3.14159265358979323846;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   check_on = 1'b0;

  dds_wave_gen_if #(.PHASE_BIT(PB), .ADDR_BIT(AB), .DATA_BIT(DB)) bus ();

  dds_wave_gen #(.DATA_BIT(DB), .ADDR_BIT(AB), .PHASE_BIT(PB)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial forever #5 sclk = ~sclk;

  typedef struct {
    int due;
    int value;
  } pend_t;

  pend_t      pend_q[$];
  longint     m_acc   = 0;
  logic [1:0] m_wav   = 2'b00;
  int         m_data  = 0;
  bit         m_valid = 1'b0;
  int         edge_n  = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Waveform values straight from their mathematical definitions.
  function automatic int ideal_sample(input logic [1:0] w, input int a);
    real y, r;
    int  half;
    half = 1 << (AB - 1);
    case (w)
      2'b00: begin
        y = real'((1 << (DB - 1)) - 1) * $sin(2.0 * PI * real'(a) / real'(1 << AB));
        r = (y >= 0.0) ? $floor(y + 0.5) : -$floor(-y + 0.5);
        return $rtoi(r) + (1 << (DB - 1));
      end
      2'b01:   return (a < half) ? 2 * a : 2 * ((1 << AB) - 1 - a);
      2'b10:   return a;
      default: return (a < half) ? (1 << DB) - 1 : 0;
    endcase
  endfunction

  task automatic model_reset();
    pend_q.delete();
    m_acc   = 0;
    m_wav   = 2'b00;
    m_data  = 0;
    m_valid = 1'b0;
    edge_n  = 0;
  endtask

  task automatic model_step();
    pend_t  p;
    longint nxt;
    int     a;
    edge_n++;
    if (bus.clr) begin
      pend_q.delete();
      m_valid = 1'b0;
      m_acc   = 0;
      m_wav   = bus.wav_select;
    end else begin
      m_valid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
        m_data  = pend_q[0].value;
        m_valid = 1'b1;
        void'(pend_q.pop_front());
      end
      if (bus.en) begin
        a = int'(((m_acc >> (PB - AB)) + longint'(bus.phase_offset)) % (longint'(1) << AB));
        p.due   = edge_n + DDS_LAT - 1;
        p.value = ideal_sample(m_wav, a);
        pend_q.push_back(p);
        nxt = m_acc + longint'(bus.freq_word);
        if (nxt >= (longint'(1) << PB)) begin
          nxt   = nxt - (longint'(1) << PB);
          m_wav = bus.wav_select;
        end
        m_acc = nxt;
      end else begin
        m_wav = bus.wav_select;
      end
    end
  endtask

  initial forever begin
    @(posedge sclk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  initial forever begin
    @(negedge sclk);
    if (rst_n && check_on) begin
      check_output("model_valid", int'(bus.data_valid), int'(m_valid));
      check_output("model_data", int'(bus.data), m_data);
      check_output("model_wav", int'(bus.wav_active), int'(m_wav));
    end
  end

  task automatic apply_stimulus(input bit e, input bit c, input logic [PB-1:0] fw,
                                input logic [AB-1:0] off, input logic [1:0] sel);
    bus.en           = e;
    bus.clr          = c;
    bus.freq_word    = fw;
    bus.phase_offset = off;
    bus.wav_select   = wav_e'(sel);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge sclk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    apply_stimulus(0, 0, '0, '0, WAV_SIN);
    rst_n = 1'b0;
    run_cycles(3);
    check_output("reset_data", int'(bus.data), 0);
    check_output("reset_valid", int'(bus.data_valid), 0);
    check_output("reset_wav", int'(bus.wav_active), 0);
    rst_n    = 1'b1;
    check_on = 1'b1;

    // Sawtooth ramp, one address step per cycle, through a full wrap.
    apply_stimulus(0, 0, 32'h0010_0000, 12'd0, WAV_SAW);
    run_cycles(1);
    check_output("saw_wav", int'(bus.wav_active), 2);
    apply_stimulus(1, 0, 32'h0010_0000, 12'd0, WAV_SAW);
    for (int i = 0; i <= 4098; i++) begin
      run_cycles(1);
      if (i == 1)    check_output("saw_latency_valid", int'(bus.data_valid), 0);
      if (i == 2)    check_output("saw_first_valid", int'(bus.data_valid), 1);
      if (i == 2)    check_output("saw_d0", int'(bus.data), 0);
      if (i == 3)    check_output("saw_d1", int'(bus.data), 1);
      if (i == 4)    check_output("saw_d2", int'(bus.data), 2);
      if (i == 4097) check_output("saw_top", int'(bus.data), 4095);
      if (i == 4098) check_output("saw_wrap", int'(bus.data), 0);
    end

    // Sine key points over a full period, then with a quarter-period offset.
    apply_stimulus(0, 1, 32'h0010_0000, 12'd0, WAV_SIN);
    run_cycles(1);
    check_output("clr_valid", int'(bus.data_valid), 0);
    apply_stimulus(1, 0, 32'h0010_0000, 12'd0, WAV_SIN);
    for (int i = 0; i <= 3074; i++) begin
      run_cycles(1);
      if (i == 2)    check_output("sin_0", int'(bus.data), 2048);
      if (i == 1026) check_output("sin_1024", int'(bus.data), 4095);
      if (i == 2050) check_output("sin_2048", int'(bus.data), 2048);
      if (i == 3074) check_output("sin_3072", int'(bus.data), 1);
    end
    apply_stimulus(0, 1, 32'h0010_0000, 12'd1024, WAV_SIN);
    run_cycles(1);
    apply_stimulus(1, 0, 32'h0010_0000, 12'd1024, WAV_SIN);
    run_cycles(3);
    check_output("sin_offset_first", int'(bus.data), 4095);

    // Frozen phase: triangle and square selected only through the offset.
    apply_stimulus(0, 1, '0, 12'd2047, WAV_TRI);
    run_cycles(1);
    apply_stimulus(1, 0, '0, 12'd2047, WAV_TRI);
    run_cycles(3);
    check_output("tri_2047", int'(bus.data), 4094);
    apply_stimulus(1, 0, '0, 12'd2048, WAV_TRI);
    run_cycles(3);
    check_output("tri_2048", int'(bus.data), 4094);
    apply_stimulus(1, 0, '0, 12'd0, WAV_TRI);
    run_cycles(3);
    check_output("tri_0", int'(bus.data), 0);
    apply_stimulus(0, 0, '0, 12'd0, WAV_SQU);
    run_cycles(1);
    check_output("squ_switch_idle", int'(bus.wav_active), 3);
    apply_stimulus(1, 0, '0, 12'd2048, WAV_SQU);
    run_cycles(3);
    check_output("squ_2048", int'(bus.data), 0);
    apply_stimulus(1, 0, '0, 12'd0, WAV_SQU);
    run_cycles(3);
    check_output("squ_0", int'(bus.data), 4095);
    apply_stimulus(1, 0, '0, 12'd0, WAV_SAW);
    run_cycles(5);
    check_output("frozen_no_switch", int'(bus.wav_active), 3);
    check_output("frozen_data", int'(bus.data), 4095);

    // Deferred switch at the wrap, then clear taking priority over enable.
    apply_stimulus(1, 1, 32'h1000_0000, 12'd0, WAV_SIN);
    run_cycles(1);
    check_output("defer_clr_wav", int'(bus.wav_active), 0);
    apply_stimulus(1, 0, 32'h1000_0000, 12'd0, WAV_SIN);
    for (int i = 0; i <= 19; i++) begin
      run_cycles(1);
      if (i == 4)  apply_stimulus(1, 0, 32'h1000_0000, 12'd0, WAV_SQU);
      if (i == 14) check_output("defer_hold", int'(bus.wav_active), 0);
      if (i == 15) check_output("defer_switch", int'(bus.wav_active), 3);
      if (i == 17) check_output("defer_last_sin", int'(bus.data), 1265);
      if (i == 18) check_output("defer_first_squ", int'(bus.data), 4095);
    end
    apply_stimulus(1, 1, 32'h1000_0000, 12'd3000, WAV_SQU);
    run_cycles(1);
    check_output("clr_prio_valid", int'(bus.data_valid), 0);
    check_output("clr_prio_hold", int'(bus.data), 4095);
    apply_stimulus(1, 0, 32'h1000_0000, 12'd3000, WAV_SQU);
    for (int j = 0; j <= 2; j++) begin
      run_cycles(1);
      if (j < 2)  check_output("clr_refill_valid", int'(bus.data_valid), 0);
      if (j == 2) check_output("clr_first_valid", int'(bus.data_valid), 1);
      if (j == 2) check_output("clr_first_data", int'(bus.data), 0);
    end

    // Asynchronous reset in the middle of a running stream.
    apply_stimulus(1, 0, 32'h1000_0000, 12'd0, WAV_SQU);
    run_cycles(4);
    check_output("pre_reset_data", int'(bus.data), 4095);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_data", int'(bus.data), 0);
    check_output("async_reset_valid", int'(bus.data_valid), 0);
    check_output("async_reset_wav", int'(bus.wav_active), 0);
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
